// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic logic is_signed(input logic [2:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_muldiv(input logic [2:0] op);
        return op <= DIVU;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Shared shift/add multiply and restoring-divide datapath on unsigned magnitudes.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0]   b_reg;
    logic               div_mode;
    logic [WIDTH:0]     lhs;
    logic [WIDTH+1:0]   rhs;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH-1:0] acc_nxt;

    // One adder serves both modes: add b for multiply, subtract b (two's complement) for divide.
    always_comb begin
        lhs = div_mode ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
        rhs = div_mode ? ~{2'b00, b_reg} : {2'b00, b_reg};
        sum = {1'b0, lhs} + rhs + {{(WIDTH+1){1'b0}}, div_mode};
    end

    always_comb begin
        acc_nxt = acc;
        if (div_mode) begin
            if (!sum[WIDTH+1])
                acc_nxt = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_nxt = {sum[WIDTH:0], acc[WIDTH-1:1]};
            else
                acc_nxt = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            b_reg    <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, a_in};
            b_reg    <= b_in;
            div_mode <= div_mode_in;
        end else if (step) begin
            acc      <= acc_nxt;
        end
    end

endmodule

// File: rtl/pipe_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO and pipeline cancel.
module pipe_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   b_raw;
    logic               op_sgn;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz_pend;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    always_comb begin
        a_mag = (op_sgn && a_raw[WIDTH-1]) ? (~a_raw + 1'b1) : a_raw;
        b_mag = (op_sgn && b_raw[WIDTH-1]) ? (~b_raw + 1'b1) : b_raw;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .reset       (reset),
        .load        (state == PREP),
        .step        (state == RUN),
        .div_mode_in (op_div),
        .a_in        (a_mag),
        .b_in        (b_mag),
        .acc         (acc)
    );

    // Divide by zero bypasses sign correction: the core leaves all-ones/|a| which is not the contract.
    always_comb begin
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quot_fix = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (!op_div) begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end else if (dz_pend) begin
            hi_res = a_raw;
            lo_res = '1;
        end else begin
            hi_res = rem_fix;
            lo_res = quot_fix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            a_raw    <= '0;
            b_raw    <= '0;
            op_sgn   <= 1'b0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_pend  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (cancel && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !cancel) begin
                            if (is_muldiv(op)) begin
                                state    <= PREP;
                                busy     <= 1'b1;
                                a_raw    <= src_a;
                                b_raw    <= src_b;
                                op_sgn   <= is_signed(op);
                                op_div   <= is_div(op);
                                div_zero <= 1'b0;
                            end else if (op == MTHI) begin
                                hi <= src_a;
                            end else if (op == MTLO) begin
                                lo <= src_a;
                            end
                        end
                    end
                    PREP: begin
                        state   <= RUN;
                        cnt     <= CNT_W'(WIDTH - 1);
                        neg_res <= op_sgn && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                        neg_rem <= op_sgn && a_raw[WIDTH-1];
                        dz_pend <= op_div && (b_raw == '0);
                    end
                    RUN: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= FIX;
                    end
                    FIX: begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        hi       <= hi_res;
                        lo       <= lo_res;
                        div_zero <= dz_pend;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Randomized bench for pipe_muldiv_unit against an arithmetic reference model.
module tb_pipe_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         cancel = 1'b0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_hi, m_lo;
    logic [W-1:0] r_hi, r_lo;
    logic         r_dz;
    int           m_left;

    pipe_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_left = 0;
    endtask

    task automatic model_launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p, q, r;
        logic [63:0] pu;
        r_dz = 0;
        case (o)
            3'd0: begin p = longint'(int'(a)) * longint'(int'(b)); pu = 64'(p); r_hi = pu[63:32]; r_lo = pu[31:0]; end
            3'd1: begin pu = {32'h0, a} * {32'h0, b}; r_hi = pu[63:32]; r_lo = pu[31:0]; end
            default: begin
                if (b == 0) begin
                    r_lo = '1; r_hi = a; r_dz = 1;
                end else if (o == 3'd2) begin
                    q = longint'(int'(a)) / longint'(int'(b));
                    r = longint'(int'(a)) % longint'(int'(b));
                    r_lo = q[31:0]; r_hi = r[31:0];
                end else begin
                    r_lo = a / b; r_hi = a % b;
                end
            end
        endcase
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        m_done = 0;
        if (m_busy) begin
            if (cancel) m_busy = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_hi = r_hi; m_lo = r_lo; m_dz = r_dz;
                end
            end
        end else if (start && !cancel) begin
            if (op <= 3'd3) begin
                model_launch(op, src_a, src_b);
                m_busy = 1; m_left = W + 2; m_dz = 0;
            end else if (op == 3'd4) m_hi = src_a;
            else if (op == 3'd5) m_lo = src_a;
        end
    endtask

    task automatic compare_all();
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("div_zero", 64'(div_zero), 64'(m_dz));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1; op = o; src_a = a; src_b = b;
        cycle();
        start = 0;
    endtask

    task automatic wait_done(output int k, output int busy_cycles);
        busy_cycles = busy ? 1 : 0;
        for (k = 1; k <= 100; k++) begin
            cycle();
            if (done) break;
            if (busy) busy_cycles++;
        end
        if (k > 100) chk("done_timeout", 64'(k), 64'(0));
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, bc;
        logic [W-1:0] keep_hi, keep_lo;
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 0;
        cycle();

        // 1. MULTU latency and result
        launch(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done(k, bc);
        chk("multu_latency", 64'(k), 64'd34);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        // 2. MULT signed, busy duration
        launch(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done(k, bc);
        chk("mult_busy_cycles", 64'(bc), 64'd34);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        // 3. DIV signed and overflow case
        launch(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(k, bc);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(k, bc);
        chk("divmin_lo", 64'(lo), 64'h8000_0000);
        chk("divmin_hi", 64'(hi), 64'h0);
        chk("divmin_flag", 64'(div_zero), 64'h0);

        // 4. DIVU by zero, then MULTU clears the flag
        launch(3'd3, 32'h1234, 32'd0);
        wait_done(k, bc);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(hi), 64'h1234);
        chk("dz_flag", 64'(div_zero), 64'h1);
        launch(3'd1, 32'd3, 32'd5);
        chk("dz_cleared", 64'(div_zero), 64'h0);
        wait_done(k, bc);
        chk("mulu15_lo", 64'(lo), 64'd15);

        // 5. start-while-busy ignored, then cancel mid-RUN
        keep_hi = hi; keep_lo = lo;
        launch(3'd3, 32'd100, 32'd7);
        cycle();                               // PREP
        cycle(); cycle();                      // RUN 1, 2
        start = 1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
        cycle();                               // RUN 3 with start
        start = 0;
        cycle();                               // RUN 4
        cancel = 1;
        cycle();                               // RUN 5 with cancel
        cancel = 0;
        chk("cancel_busy", 64'(busy), 64'h0);
        chk("cancel_hi", 64'(hi), 64'(keep_hi));
        chk("cancel_lo", 64'(lo), 64'(keep_lo));
        repeat (40) cycle();

        // cancel suppresses a same-edge MTHI
        start = 1; op = 3'd4; src_a = 32'hDEAD_BEEF; cancel = 1;
        cycle();
        start = 0; cancel = 0;
        chk("mthi_cancel", 64'(hi), 64'(keep_hi));

        // 6. reset mid-RUN, then MTHI/MTLO
        launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) cycle();
        reset = 1;
        #1;
        model_reset();
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        cycle();
        reset = 0;
        cycle();
        launch(3'd4, 32'hAA, 32'd0);
        chk("mthi_hi", 64'(hi), 64'hAA);
        launch(3'd5, 32'h55, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'h55);
        chk("mtlo_hi_kept", 64'(hi), 64'hAA);
        chk("mtlo_no_done", 64'(done), 64'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            op     = 3'($urandom_range(0, 7));
            src_a  = rnd_val();
            src_b  = rnd_val();
            cancel = ($urandom_range(0, 60) == 0);
            cycle();
        end
        start = 0; cancel = 0;
        repeat (40) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
